// File: rtl/dest_reg_tracker.sv
// Destination-register tracker: EX/MEM and MEM/WB dest history, operand forwarding selects, load-use stall.
// Optional WB-stage forwarding is built when DEST_TRACK_WB_FWD_EN is defined.
module dest_reg_tracker #(
  parameter int REG_BITS = 5
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic [REG_BITS-1:0] DestRegEX,
  input  logic                RegWriteEX,
  input  logic                MemReadEX,
  input  logic                FlushEX,
  input  logic                Hold,
  input  logic [REG_BITS-1:0] RsEX,
  input  logic [REG_BITS-1:0] RtEX,
  input  logic [REG_BITS-1:0] RsID,
  input  logic [REG_BITS-1:0] RtID,
  input  logic                UsesRtID,
  output logic [REG_BITS-1:0] DestRegMEM,
  output logic [REG_BITS-1:0] DestRegWB,
  output logic                RegWriteMEM,
  output logic                RegWriteWB,
  output logic [1:0]          ForwardA,
  output logic [1:0]          ForwardB,
  output logic                LoadUseStall
);

  logic [REG_BITS-1:0] r_dest_mem;
  logic [REG_BITS-1:0] r_dest_wb;
  logic                r_we_mem;
  logic                r_we_wb;

  logic w_ex_nz;
  logic w_we_ex;
  logic w_a_mem;
  logic w_b_mem;
  logic w_a_wb;
  logic w_b_wb;
  logic w_rs_nz;
  logic w_rt_nz;

  assign w_ex_nz = (DestRegEX != '0);
  assign w_we_ex = RegWriteEX & ~FlushEX & w_ex_nz;
  assign w_rs_nz = (RsEX != '0);
  assign w_rt_nz = (RtEX != '0);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_dest_mem <= '0;
      r_dest_wb  <= '0;
      r_we_mem   <= 1'b0;
      r_we_wb    <= 1'b0;
    end else if (!Hold) begin
      r_we_mem   <= w_we_ex;
      r_dest_mem <= FlushEX ? '0 : DestRegEX;
      r_we_wb    <= r_we_mem;
      r_dest_wb  <= r_dest_mem;
    end
  end

  assign w_a_mem = r_we_mem & (r_dest_mem == RsEX) & w_rs_nz;
  assign w_b_mem = r_we_mem & (r_dest_mem == RtEX) & w_rt_nz;

`ifdef DEST_TRACK_WB_FWD_EN
  assign w_a_wb = r_we_wb & (r_dest_wb == RsEX) & w_rs_nz;
  assign w_b_wb = r_we_wb & (r_dest_wb == RtEX) & w_rt_nz;
`else
  // write-first register file covers the WB distance
  assign w_a_wb = 1'b0;
  assign w_b_wb = 1'b0;
`endif

  always_comb begin
    ForwardA = 2'b00;
    ForwardB = 2'b00;
    if (w_a_mem)     ForwardA = 2'b10;
    else if (w_a_wb) ForwardA = 2'b01;
    if (w_b_mem)     ForwardB = 2'b10;
    else if (w_b_wb) ForwardB = 2'b01;
  end

  assign LoadUseStall = MemReadEX & w_we_ex &
                        ((DestRegEX == RsID) |
                         (UsesRtID & (DestRegEX == RtID)));

  assign DestRegMEM  = r_dest_mem;
  assign DestRegWB   = r_dest_wb;
  assign RegWriteMEM = r_we_mem;
  assign RegWriteWB  = r_we_wb;

endmodule
